// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg : shared encodings and constants for the HI/LO multiply/divide unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// div_step : one combinational radix-2 restoring division step
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    shifted  = {rem, dividend_bit};
    q_bit    = (shifted >= {2'b00, divisor});
    diff     = shifted[WIDTH:0] - {1'b0, divisor};
    rem_next = q_bit ? diff : shifted[WIDTH:0];
  end

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// ============================================================================
// mdu_hilo : iterative multiply/divide unit with architectural HI/LO registers
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

  state_t           state;
  logic [5:0]       count;
  logic [WIDTH-1:0] opa;       // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0] opb;       // multiplier or divisor
  logic [WIDTH:0]   rem;
  logic             neg_q;
  logic             neg_r;

  logic             is_signed;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;

  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    rs_mag    = (is_signed && rs_val[WIDTH-1]) ? (WIDTH'(0) - rs_val) : rs_val;
    rt_mag    = (is_signed && rt_val[WIDTH-1]) ? (WIDTH'(0) - rt_val) : rt_val;
    prod      = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
    prod_fix  = neg_q ? ((2*WIDTH)'(0) - prod) : prod;
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem          (rem),
    .dividend_bit (opa[WIDTH-1]),
    .divisor      (opb),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      opa   <= '0;
      opb   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                opa   <= rs_mag;
                opb   <= rt_mag;
                neg_q <= is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                neg_r <= 1'b0;
                busy  <= 1'b1;
                state <= MUL;
              end
              OP_DIV, OP_DIVU: begin
                // A zero divisor runs the raw dividend through unsigned, which
                // naturally yields all-ones quotient and remainder = dividend.
                if (rt_val == '0) begin
                  opa   <= rs_val;
                  opb   <= '0;
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                end else begin
                  opa   <= rs_mag;
                  opb   <= rt_mag;
                  neg_q <= is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                  neg_r <= is_signed && rs_val[WIDTH-1];
                end
                rem   <= '0;
                count <= '0;
                busy  <= 1'b1;
                state <= DIV;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        MUL: begin
          hi    <= prod_fix[2*WIDTH-1:WIDTH];
          lo    <= prod_fix[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        DIV: begin
          rem   <= rem_next;
          opa   <= {opa[WIDTH-2:0], q_bit};
          count <= count + 6'd1;
          if (count == LAST_STEP) state <= FIX;
        end
        FIX: begin
          lo    <= neg_q ? (WIDTH'(0) - opa) : opa;
          hi    <= neg_r ? (WIDTH'(0) - rem[WIDTH-1:0]) : rem[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mdu_hilo.md
# mdu_hilo

Multiply/divide unit with architectural HI/LO registers, sitting beside the execute-stage ALU and fed by the same rs/rt operand buses. It runs MULT/MULTU/DIV/DIVU and MTHI/MTLO. The ALU deliberately has no divider, because a combinational divide broke timing. This block divides with an iterative radix-2 restoring algorithm instead, and raises `busy` so the core stalls MFHI/MFLO and further mult/div issue.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Only 32 is supported.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: issue strobe. Sampled only when `busy`=0.
- `op`  in  3: operation select.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- `rs_val`  in  32: multiplicand, dividend, or MTHI/MTLO source.
- `rt_val`  in  32: multiplier or divisor.
- `busy`  out  1: an operation is in flight. Core must stall HI/LO reads and new issue.
- `done`  out  1: one-cycle pulse when HI/LO have just been updated by MULT/DIV.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
- States:
  - IDLE: `start`=1 with MULT* → MUL. `start`=1 with DIV* → DIV. MTHI/MTLO writes directly, state stays IDLE.
  - MUL: 32x32→64 product of the operands registered at issue. Next edge writes {HI,LO} and returns to IDLE.
  - DIV: one restoring step per cycle, 32 steps, 6-bit counter. Then → FIX.
  - FIX: apply sign correction, write LO=quotient and HI=remainder, → IDLE.
- Operands are captured at the issue edge. Later changes on `rs_val`/`rt_val` have no effect.
- Signed operations (MULT, DIV):
  - Operands are converted to magnitude at issue.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / -1 → LO=0x80000000, HI=0. This is the natural wrap; it is not trapped.
- Divide by zero (either signedness):
  - LO=0xFFFFFFFF, HI=rs_val as issued, with no sign correction.
  - Same latency as a normal divide. No exception.
- MTHI/MTLO:
  - Written on the issue edge. `busy` and `done` stay 0.
  - Only the targeted register changes.
- `start` while `busy`=1 is ignored entirely, including MTHI/MTLO. The core guarantees the stall.
- Undefined `op` with `start`=1: no state change.
- Reset (asynchronous, any state):
  - State → IDLE.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0.
  - Counter and operand registers are cleared.
  - An in-flight operation is discarded and nothing is written.

## Timing
- Let issue edge E be the edge at which IDLE samples `start`=1.
- MULT/MULTU:
  - `busy`=1 during the cycle after E.
  - HI/LO are written at edge E+1.
  - `done`=1 in the cycle after E+1, and `busy`=0 in that cycle.
- DIV/DIVU:
  - `busy`=1 from after E through the FIX cycle.
  - The iterations complete at edges E+1 through E+32.
  - FIX writes HI/LO at edge E+33.
  - `done`=1 and `busy`=0 in the cycle after E+33.
- A new `start` may be issued in the same cycle that `done`=1. There is no bubble.
- `hi`/`lo` are plain register outputs and change only on write edges.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `mdu_pkg`:
  - `op` encodings as localparams.
  - State enum {IDLE, MUL, DIV, FIX}.
  - `DIV_STEPS` = 32.
- One sub-module, `div_step`: combinational single restoring step.
  - Inputs: partial remainder (33 bits), dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- The FSM, counter, sign handling and HI/LO registers live in `mdu_hilo`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 at E+1; `done` pulse in the cycle after E+1.
- MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU 100 / 7 → LO=0x0000000E, HI=0x00000002.
  - `busy` high for exactly 33 cycles.
  - `done` in the cycle after E+33.
  - A second `start` during `busy` is ignored.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- DIVU 5 / 0 → LO=0xFFFFFFFF, HI=5.
- MTHI 0x12345678 → `hi` updates at E, `lo` unchanged, `busy`=0.
- Reset during DIV:
  - Assert `reset` at cycle 10 after issue → `busy`, `done`, `hi`, `lo` = 0 immediately.
  - After release, a MULTU 2×3 completes normally: LO=6.
